systolic_pe_multilane: RTL and testbench

Second-generation systolic-array processing element: LANES independent signed MAC lanes share one moving activation. Each lane has a double-buffered weight register. The datapath is a two-stage pipeline with valid tracking. A runtime mode selects weight-stationary operation (partial sums flow through the chain) or output-stationary operation (local accumulation, then drain). It tiles into the array fabric in the same position as the first-generation PE.

---
 rtl/pe_pkg.sv | 47 ++++
 rtl/pe_mac_lane.sv | 118 +++++++++++
 rtl/systolic_pe_multilane.sv | 105 ++++++++++
 tb/tb_systolic_pe_multilane.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the multilane systolic PE.
// Optional feature macro: PE_SATURATE_EN (saturating adders and sticky sat flags).
package pe_pkg;

    localparam logic PE_MODE_WS = 1'b0;
    localparam logic PE_MODE_OS = 1'b1;

    localparam int PE_DATA_WIDTH = 8;
    localparam int PE_ACC_WIDTH  = 24;
    localparam int PE_LANES      = 2;

    // Per-cycle selection of what psum_out loads in every lane.
    localparam logic [1:0] PE_OUT_HOLD  = 2'd0;
    localparam logic [1:0] PE_OUT_WS    = 2'd1;
    localparam logic [1:0] PE_OUT_DRAIN = 2'd2;
    localparam logic [1:0] PE_OUT_PASS  = 2'd3;

    typedef struct packed {
        logic signed [63:0] sum;
        logic               sat;
    } pe_sat_result_t;

    // Signed add clamped to a width-bit two's complement range (width <= 63).
    // Operands must already be sign-extended to 64 bits.
    function automatic pe_sat_result_t pe_sat_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int width);
        logic signed [64:0] full;
        logic signed [64:0] max_v;
        logic signed [64:0] min_v;
        pe_sat_result_t     r;
        full  = {a[63], a} + {b[63], b};
        max_v = (65'sd1 <<< (width - 1)) - 65'sd1;
        min_v = -(65'sd1 <<< (width - 1));
        r.sum = full[63:0];
        r.sat = 1'b0;
        if (full > max_v) begin
            r.sum = max_v[63:0];
            r.sat = 1'b1;
        end else if (full < min_v) begin
            r.sum = min_v[63:0];
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_mac_lane.sv
// One MAC lane: double-buffered weight, stage-1 product/psum registers,
// stage-2 WS adder / OS accumulator and the lane's psum_out register.
// Optional feature macro: PE_SATURATE_EN (clamping adders, sticky sat_flag).
module pe_mac_lane
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int ACC_WIDTH  = PE_ACC_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] weight_in,
    input  logic                         weight_load,
    input  logic                         weight_swap,
    input  logic                         act_valid_in,
    input  logic signed [DATA_WIDTH-1:0] activation_in,
    input  logic signed [ACC_WIDTH-1:0]  psum_in,
    input  logic                         valid_s1,
    input  logic                         mode_s1,
    input  logic                         clear_acc,
    input  logic [1:0]                   out_sel,
    output logic signed [ACC_WIDTH-1:0]  psum_out,
    output logic                         sat_flag
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [DATA_WIDTH-1:0] bank0;
    logic signed [DATA_WIDTH-1:0] bank1;
    logic                         bank_sel;
    logic signed [DATA_WIDTH-1:0] active_w;
    logic signed [PW-1:0]         product_d;
    logic signed [PW-1:0]         product_s1;
    logic signed [ACC_WIDTH-1:0]  psum_s1;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  acc_base;
    logic signed [ACC_WIDTH-1:0]  ws_sum;
    logic signed [ACC_WIDTH-1:0]  os_sum;
    logic                         os_op;

    assign active_w  = bank_sel ? bank1 : bank0;
    assign product_d = PW'(activation_in) * PW'(active_w);
    assign prod_ext  = ACC_WIDTH'(product_s1);
    assign acc_base  = clear_acc ? '0 : acc;
    assign os_op     = valid_s1 && (mode_s1 == PE_MODE_OS);

`ifdef PE_SATURATE_EN
    pe_sat_result_t ws_r;
    pe_sat_result_t os_r;
    logic           sat_q;

    assign ws_r   = pe_sat_add(64'(psum_s1), 64'(prod_ext), ACC_WIDTH);
    assign os_r   = pe_sat_add(64'(acc_base), 64'(prod_ext), ACC_WIDTH);
    assign ws_sum = ws_r.sum[ACC_WIDTH-1:0];
    assign os_sum = os_r.sum[ACC_WIDTH-1:0];

    // Sticky clamp indicator; clear_acc wipes history but a clamp in the same cycle still sets it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= (clear_acc ? 1'b0 : sat_q)
                   | ((out_sel == PE_OUT_WS) & ws_r.sat)
                   | (os_op & os_r.sat);
        end
    end
    assign sat_flag = sat_q;
`else
    assign ws_sum   = psum_s1 + prod_ext;
    assign os_sum   = acc_base + prod_ext;
    assign sat_flag = 1'b0;
`endif

    // Weight banks: load targets the shadow; load+swap together makes the new value active next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank0    <= '0;
            bank1    <= '0;
            bank_sel <= 1'b0;
        end else begin
            if (weight_load) begin
                if (bank_sel) bank0 <= weight_in;
                else          bank1 <= weight_in;
            end
            if (weight_swap) bank_sel <= ~bank_sel;
        end
    end

    // Stage 1 captures the product and upstream psum only for valid activations.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            product_s1 <= '0;
            psum_s1    <= '0;
        end else if (act_valid_in) begin
            product_s1 <= product_d;
            psum_s1    <= psum_in;
        end
    end

    // Stage 2: OS accumulator, and the shared output register (drain reads acc before its update).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            psum_out <= '0;
        end else begin
            if (os_op)          acc <= os_sum;
            else if (clear_acc) acc <= '0;
            case (out_sel)
                PE_OUT_WS:    psum_out <= ws_sum;
                PE_OUT_DRAIN: psum_out <= acc;
                PE_OUT_PASS:  psum_out <= psum_in;
                default:      psum_out <= psum_out;
            endcase
        end
    end

endmodule

// File: rtl/systolic_pe_multilane.sv
// Multilane systolic PE: LANES MAC lanes share one moving activation.
// Runtime mode: weight-stationary (psum chains through) or output-stationary
// (local accumulate, then drain). Owns the activation pipe and shared valid/mode.
// Optional feature macro: PE_SATURATE_EN (saturating adders, sticky sat_flag).
module systolic_pe_multilane
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int ACC_WIDTH  = PE_ACC_WIDTH,
    parameter int LANES      = PE_LANES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [LANES*DATA_WIDTH-1:0]  weight_in,
    input  logic                         weight_load,
    input  logic                         weight_swap,
    input  logic                         mode,
    input  logic                         clear_acc,
    input  logic                         drain,
    input  logic                         act_valid_in,
    input  logic [DATA_WIDTH-1:0]        activation_in,
    input  logic                         psum_valid_in,
    input  logic [LANES*ACC_WIDTH-1:0]   psum_in,
    output logic                         act_valid_out,
    output logic [DATA_WIDTH-1:0]        activation_out,
    output logic                         psum_valid_out,
    output logic [LANES*ACC_WIDTH-1:0]   psum_out,
    output logic [LANES-1:0]             sat_flag
);

    if (ACC_WIDTH < 2 * DATA_WIDTH + 1) begin : g_bad_acc_width
        $error("systolic_pe_multilane: ACC_WIDTH must be >= 2*DATA_WIDTH+1");
    end
    if (LANES < 1) begin : g_bad_lanes
        $error("systolic_pe_multilane: LANES must be >= 1");
    end
`ifdef PE_SATURATE_EN
    if (ACC_WIDTH > 63) begin : g_bad_sat_width
        $error("systolic_pe_multilane: saturating build supports ACC_WIDTH <= 63");
    end
`endif

    logic       valid_s1;
    logic       mode_s1;
    logic [1:0] out_sel;
    logic       psum_valid_d;

    // Output source: a WS result in stage 2 wins; otherwise OS drain beats pass-through.
    always_comb begin
        out_sel      = PE_OUT_HOLD;
        psum_valid_d = 1'b0;
        if (valid_s1 && (mode_s1 == PE_MODE_WS)) begin
            out_sel      = PE_OUT_WS;
            psum_valid_d = 1'b1;
        end else if (mode == PE_MODE_OS) begin
            if (drain) begin
                out_sel      = PE_OUT_DRAIN;
                psum_valid_d = 1'b1;
            end else if (psum_valid_in) begin
                out_sel      = PE_OUT_PASS;
                psum_valid_d = 1'b1;
            end
        end
    end

    // Activation forwarding, stage-1 valid and per-op mode capture, output valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_valid_out  <= 1'b0;
            activation_out <= '0;
            valid_s1       <= 1'b0;
            mode_s1        <= PE_MODE_WS;
            psum_valid_out <= 1'b0;
        end else begin
            act_valid_out  <= act_valid_in;
            activation_out <= activation_in;
            valid_s1       <= act_valid_in;
            if (act_valid_in) mode_s1 <= mode;
            psum_valid_out <= psum_valid_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pe_mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .clk           (clk),
            .rst_n         (rst_n),
            .weight_in     (weight_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .weight_load   (weight_load),
            .weight_swap   (weight_swap),
            .act_valid_in  (act_valid_in),
            .activation_in (activation_in),
            .psum_in       (psum_in[i*ACC_WIDTH +: ACC_WIDTH]),
            .valid_s1      (valid_s1),
            .mode_s1       (mode_s1),
            .clear_acc     (clear_acc),
            .out_sel       (out_sel),
            .psum_out      (psum_out[i*ACC_WIDTH +: ACC_WIDTH]),
            .sat_flag      (sat_flag[i])
        );
    end

endmodule

// File: tb/tb_systolic_pe_multilane.sv
// Directed bench for systolic_pe_multilane (LANES=2, 8-bit data, 24-bit acc).
// Honors PE_SATURATE_EN for the overflow expectations.
module tb_systolic_pe_multilane;

    localparam int DW = 8;
    localparam int AW = 24;
    localparam int L  = 2;

    logic            clk;
    logic            rst_n;
    logic [L*DW-1:0] weight_in;
    logic            weight_load;
    logic            weight_swap;
    logic            mode;
    logic            clear_acc;
    logic            drain;
    logic            act_valid_in;
    logic [DW-1:0]   activation_in;
    logic            psum_valid_in;
    logic [L*AW-1:0] psum_in;
    logic            act_valid_out;
    logic [DW-1:0]   activation_out;
    logic            psum_valid_out;
    logic [L*AW-1:0] psum_out;
    logic [L-1:0]    sat_flag;

    systolic_pe_multilane #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LANES(L)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .weight_in      (weight_in),
        .weight_load    (weight_load),
        .weight_swap    (weight_swap),
        .mode           (mode),
        .clear_acc      (clear_acc),
        .drain          (drain),
        .act_valid_in   (act_valid_in),
        .activation_in  (activation_in),
        .psum_valid_in  (psum_valid_in),
        .psum_in        (psum_in),
        .act_valid_out  (act_valid_out),
        .activation_out (activation_out),
        .psum_valid_out (psum_valid_out),
        .psum_out       (psum_out),
        .sat_flag       (sat_flag)
    );

    typedef struct {
        int l0;
        int l1;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   wa0;
    int   wa1;
    int   ov0;
    int   ov1;
    logic [1:0] sat_exp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [L*DW-1:0] pack_w(input int a, input int b);
        logic [DW-1:0] wa;
        logic [DW-1:0] wb;
        wa = DW'(a);
        wb = DW'(b);
        return {wb, wa};
    endfunction

    function automatic logic [L*AW-1:0] pack_p(input int a, input int b);
        logic [AW-1:0] pa;
        logic [AW-1:0] pb;
        pa = AW'(a);
        pb = AW'(b);
        return {pb, pa};
    endfunction

    task automatic push(input int l0, input int l1, input int lat);
        exp_t e;
        e.l0  = l0;
        e.l1  = l1;
        e.cyc = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        weight_load   = 1'b0;
        weight_swap   = 1'b0;
        clear_acc     = 1'b0;
        drain         = 1'b0;
        act_valid_in  = 1'b0;
        psum_valid_in = 1'b0;
    endtask

    // Scoreboard: every psum_valid_out must match the oldest pending expectation, on its cycle.
    always @(negedge clk) begin
        if (psum_valid_out === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_psum_valid cyc=%0d observed=1 expected=0", cyc);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("psum_lane0", $signed(psum_out[AW-1:0]), e.l0);
                chk("psum_lane1", $signed(psum_out[2*AW-1:AW]), e.l1);
                chk("psum_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        weight_in     = '0;
        mode          = 1'b0;
        activation_in = '0;
        psum_in       = '0;
        idle();
        step();
        step();
        chk("rst_act_valid_out", act_valid_out, 0);
        chk("rst_activation_out", activation_out, 0);
        chk("rst_psum_valid_out", psum_valid_out, 0);
        chk("rst_psum_out", psum_out, 0);
        chk("rst_sat_flag", sat_flag, 0);
        rst_n = 1'b1;
        step();

        // WS: load {3,-2}, swap, act 5 with psum 100
        weight_in   = pack_w(3, -2);
        weight_load = 1'b1;
        step();
        weight_load = 1'b0;
        weight_swap = 1'b1;
        step();
        weight_swap   = 1'b0;
        act_valid_in  = 1'b1;
        activation_in = 8'd5;
        psum_in       = pack_p(100, 100);
        push(115, 90, 2);
        step();
        chk("act_valid_fwd", act_valid_out, 1);
        chk("activation_fwd", activation_out, 5);
        for (int i = 1; i <= 3; i++) begin
            act_valid_in  = 1'b1;
            activation_in = DW'(i);
            psum_in       = pack_p(0, 0);
            push(3 * i, -2 * i, 2);
            step();
        end
        idle();
        step();
        step();
        step();
        chk("ws_hold_lane0", $signed(psum_out[AW-1:0]), 9);
        chk("ws_hold_valid", psum_valid_out, 0);

        // Double buffer: stream acts of 1, load {7,-7} then swap; change lands the cycle after swap
        wa0 = 3;
        wa1 = -2;
        for (int i = 0; i < 8; i++) begin
            act_valid_in  = 1'b1;
            activation_in = 8'd1;
            psum_in       = pack_p(0, 0);
            weight_in     = pack_w(7, -7);
            weight_load   = (i == 2);
            weight_swap   = (i == 4);
            push(wa0, wa1, 2);
            if (i == 4) begin
                wa0 = 7;
                wa1 = -7;
            end
            step();
        end
        idle();
        step();
        step();
        step();

        // OS: clear, weight {2,-1} via load+swap, acts 1..5, drain concurrent with 5th accumulate
        mode        = 1'b1;
        clear_acc   = 1'b1;
        weight_in   = pack_w(2, -1);
        weight_load = 1'b1;
        weight_swap = 1'b1;
        step();
        idle();
        for (int i = 1; i <= 5; i++) begin
            act_valid_in  = 1'b1;
            activation_in = DW'(i);
            step();
        end
        idle();
        drain = 1'b1;
        push(20, -10, 1);
        step();
        idle();
        step();
        step();
        drain = 1'b1;
        push(30, -15, 1);
        step();
        idle();
        step();

        // OS pass-through
        psum_valid_in = 1'b1;
        psum_in       = pack_p(9, -9);
        push(9, -9, 1);
        step();
        idle();
        step();
        step();

        // Overflow: build acc to +/-8388600 with weight 120, then one 127*127 op
        clear_acc   = 1'b1;
        weight_in   = pack_w(120, -120);
        weight_load = 1'b1;
        weight_swap = 1'b1;
        step();
        idle();
        for (int i = 0; i <= 550; i++) begin
            act_valid_in  = 1'b1;
            activation_in = (i == 550) ? 8'd55 : 8'd127;
            step();
        end
        idle();
        weight_in   = pack_w(127, -127);
        weight_load = 1'b1;
        weight_swap = 1'b1;
        step();
        idle();
        drain         = 1'b1;
        act_valid_in  = 1'b1;
        activation_in = 8'd127;
        push(8388600, -8388600, 1);
        step();
        idle();
        step();
        step();
`ifdef PE_SATURATE_EN
        ov0     = 8388607;
        ov1     = -8388608;
        sat_exp = 2'b11;
`else
        ov0     = -8372487;
        ov1     = 8372487;
        sat_exp = 2'b00;
`endif
        drain = 1'b1;
        push(ov0, ov1, 1);
        step();
        idle();
        step();
        chk("sat_flag_overflow", sat_flag, sat_exp);
        clear_acc = 1'b1;
        step();
        idle();
        chk("sat_flag_cleared", sat_flag, 0);

        // Reset mid-stream with ops in stage 1 and at the output
        mode          = 1'b0;
        act_valid_in  = 1'b1;
        activation_in = 8'd1;
        psum_in       = pack_p(0, 0);
        push(127, -127, 2);
        step();
        activation_in = 8'd2;
        step();
        rst_n         = 1'b0;
        activation_in = 8'd3;
        step();
        rst_n = 1'b1;
        idle();
        chk("mrst_act_valid_out", act_valid_out, 0);
        chk("mrst_activation_out", activation_out, 0);
        chk("mrst_psum_valid_out", psum_valid_out, 0);
        chk("mrst_psum_out", psum_out, 0);
        act_valid_in  = 1'b1;
        activation_in = 8'd5;
        psum_in       = pack_p(7, -7);
        push(7, -7, 2);
        step();
        idle();
        weight_swap = 1'b1;
        step();
        idle();
        act_valid_in  = 1'b1;
        activation_in = 8'd5;
        psum_in       = pack_p(4, 4);
        push(4, 4, 2);
        step();
        idle();
        for (int i = 0; i < 4; i++) step();

        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
